sort_engine: RTL
================

// Module: sort_engine
// PURPOSE
//   Sequential bubble-sort engine over an internal N-entry register array.
//   Drives operand pairs to an external Comparer (cmp_a/cmp_b) and consumes
//   its one-hot results {lt,eq,gt} (cmp_ur unsigned, cmp_sr signed) to decide swaps.
//   Host loads data while idle, pulses start, waits for done, reads sorted array.
// PARAMETERS
//   N      8   entries to sort; N >= 2
//   WIDTH  32  data width; must match the Comparer operand width
//   AW     $clog2(N)  address width (derived, not overridden)
// PORTS
//   clk        in   1      clock, rising edge
//   rstn       in   1      asynchronous active-low reset
//   wr_en      in   1      write mem[wr_addr] <= wr_data; honoured only when busy=0
//   wr_addr    in   AW     write address
//   wr_data    in   WIDTH  write data
//   rd_addr    in   AW     read address
//   rd_data    out  WIDTH  combinational mem[rd_addr], valid at any time
//   start      in   1      begin sort; honoured only in IDLE
//   signed_md  in   1      1: use cmp_sr, 0: use cmp_ur; sampled at accepted start
//   descend    in   1      1: descending, 0: ascending; sampled at accepted start
//   cmp_a      out  WIDTH  mem[i] in CMP, else 0
//   cmp_b      out  WIDTH  mem[i+1] in CMP, else 0
//   cmp_ur     in   3      Comparer unsigned result {lt,eq,gt}, combinational
//   cmp_sr     in   3      Comparer signed result {lt,eq,gt}, combinational
//   busy       out  1      high in CMP/SWAP/DONE
//   done       out  1      one-cycle pulse in DONE
//   cycle_cnt  out  16     CMP+SWAP cycles of last sort; holds until next start
// BEHAVIOUR
//   Reset: state=IDLE, mem[*]=0, i=0, last=N-1, swapped=0, busy=0, done=0, cycle_cnt=0,
//     latched mode bits=0. Reset mid-sort aborts immediately; partial data discarded.
//   States: IDLE, CMP, SWAP, DONE.
//   IDLE: start=1 -> latch signed_md/descend, i=0, last=N-1, swapped=0, cycle_cnt=0, -> CMP.
//     wr_en and start in same cycle: write performed, then sort starts (write included).
//   CMP (1 cycle): res = signed ? cmp_sr : cmp_ur; need = descend ? res[2] : res[0].
//     Equal (res[1]) never swaps (stable). need=1 -> SWAP; need=0 -> ADVANCE.
//   SWAP (1 cycle): mem[i]<=mem[i+1], mem[i+1]<=mem[i], swapped<=1, then ADVANCE.
//   ADVANCE (same cycle as the CMP or SWAP that triggers it):
//     i+1 < last -> i<=i+1, -> CMP.
//     i+1 == last: if (!swapped_next || last==1) -> DONE; else last<=last-1, i<=0,
//     swapped<=0, -> CMP. swapped_next includes a swap made this cycle.
//   DONE (1 cycle): done=1, busy=1, -> IDLE.
//   cycle_cnt +1 every CMP and SWAP cycle, saturates at 16'hFFFF.
//   start, wr_en ignored while busy=1. Comparer treated as zero-latency combinational.
//   Result malformed (not one-hot): treat as eq, no swap.
// TESTING
//   T1 load 0..7 ascending, start, asc unsigned -> 7 CMP, 0 SWAP, cycle_cnt=7, done 8 cycles after start.
//   T2 load 7..0, start asc -> output 0..7, 28 CMP + 28 SWAP, cycle_cnt=56.
//   T3 load {1,0xFFFFFFFF,...}, N=2, asc unsigned -> {1,0xFFFFFFFF}; signed_md=1 -> {0xFFFFFFFF,1}.
//   T4 all entries 5 -> no swaps, cycle_cnt=7; descend=1 on 0..7 -> 7..0, cycle_cnt=56.
//   T5 wr_en/start pulsed while busy -> mem and sort unaffected; rd_data tracks swaps live.
//   T6 rstn low mid-sort -> busy=0, done=0, mem all 0, cycle_cnt=0 asynchronously; new sort runs clean.

Source files
------------

// File: rtl/sort_engine.sv
// Bubble-sort engine over an internal register array.
// Compares go to an external combinational comparer.
module sort_engine #(
  parameter int N = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             start,
  input  logic             signed_md,
  input  logic             descend,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic [2:0]       cmp_ur,
  input  logic [2:0]       cmp_sr,
  output logic             busy,
  output logic             done,
  output logic [15:0]      cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_SWAP,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST0 = AW'(N - 1);
  localparam logic [AW-1:0] LAST1 = AW'(1);

  state_t state, state_n;

  logic [WIDTH-1:0] mem [N];
  logic [AW-1:0] i_q, i_n, i_nx;
  logic [AW-1:0] last_q, last_n;
  logic [AW:0]   i_inc;
  logic          swapped_q, swapped_n, sw_next;
  logic          sgn_q, sgn_n, dsc_q, dsc_n;
  logic [15:0]   cnt_q, cnt_n, cnt_sat;
  logic [2:0]    res;
  logic          one_hot, need;
  logic          adv, do_swap;

  assign i_nx    = i_q + 1'b1;
  assign i_inc   = {1'b0, i_q} + 1'b1;
  assign cnt_sat = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  assign rd_data   = mem[rd_addr];
  assign cmp_a     = (state == S_CMP) ? mem[i_q] : '0;
  assign cmp_b     = (state == S_CMP) ? mem[i_nx] : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign cycle_cnt = cnt_q;

  // A malformed (non one-hot) result behaves like equal: no swap.
  always_comb begin
    res     = sgn_q ? cmp_sr : cmp_ur;
    one_hot = (res == 3'b100) || (res == 3'b010) || (res == 3'b001);
    need    = one_hot && (dsc_q ? res[2] : res[0]);
  end

  always_comb begin
    state_n   = state;
    i_n       = i_q;
    last_n    = last_q;
    swapped_n = swapped_q;
    sgn_n     = sgn_q;
    dsc_n     = dsc_q;
    cnt_n     = cnt_q;
    sw_next   = swapped_q;
    adv       = 1'b0;
    do_swap   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          sgn_n     = signed_md;
          dsc_n     = descend;
          i_n       = '0;
          last_n    = LAST0;
          swapped_n = 1'b0;
          cnt_n     = '0;
          state_n   = S_CMP;
        end
      end
      S_CMP: begin
        cnt_n = cnt_sat;
        if (need) state_n = S_SWAP;
        else      adv     = 1'b1;
      end
      S_SWAP: begin
        cnt_n     = cnt_sat;
        do_swap   = 1'b1;
        swapped_n = 1'b1;
        sw_next   = 1'b1;
        adv       = 1'b1;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // End of a pass: stop early if nothing moved.
    if (adv) begin
      if (i_inc < {1'b0, last_q}) begin
        i_n     = i_nx;
        state_n = S_CMP;
      end else if (!sw_next || last_q == LAST1) begin
        state_n = S_DONE;
      end else begin
        last_n    = last_q - 1'b1;
        i_n       = '0;
        swapped_n = 1'b0;
        state_n   = S_CMP;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      i_q       <= '0;
      last_q    <= LAST0;
      swapped_q <= 1'b0;
      sgn_q     <= 1'b0;
      dsc_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= state_n;
      i_q       <= i_n;
      last_q    <= last_n;
      swapped_q <= swapped_n;
      sgn_q     <= sgn_n;
      dsc_q     <= dsc_n;
      cnt_q     <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N; k++) mem[k] <= '0;
    end else if (do_swap) begin
      mem[i_q]  <= mem[i_nx];
      mem[i_nx] <= mem[i_q];
    end else if (wr_en && state == S_IDLE) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule
